// File: rtl/cnt_load_sched.sv
// cnt_load_sched
//   Shares one loadable up-counter among NREQ timeout requesters. A
//   round-robin arbiter picks a requester, the counter is preloaded with that
//   requester's value and counts up (while cnt_en_i is high) to all-ones, then
//   the requester's done line pulses for one cycle.
//
//   Optional build macro: CNT_ABORT_EN adds abort_i / aborted_o, which cancel
//   the interval in progress (LOAD or COUNT) without a done pulse.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   req_i       per-requester level request, held until done
//   load_val_i  packed preload values, slice k belongs to requester k
//   cnt_en_i    global count enable (counting stalls while low)
//   abort_i     (CNT_ABORT_EN) cancel the running interval
//   gnt_o       one-hot grant, registered
//   done_o      one-hot one-cycle completion pulse, registered
//   aborted_o   (CNT_ABORT_EN) one-cycle abort acknowledge, registered
//   busy_o      high in any state other than IDLE
//   cnt_o       current counter value
//   tc_o        terminal count: counter all-ones while in COUNT
module cnt_load_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] load_val_i,
  input  logic                  cnt_en_i,
`ifdef CNT_ABORT_EN
  input  logic                  abort_i,
  output logic                  aborted_o,
`endif
  output logic [NREQ-1:0]       gnt_o,
  output logic [NREQ-1:0]       done_o,
  output logic                  busy_o,
  output logic [WIDTH-1:0]      cnt_o,
  output logic                  tc_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [NREQ-1:0]  ONE     = NREQ'(1);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
  } arb_t;

  state_t                     state;
  logic [IW-1:0]              sel;
  logic [IW-1:0]              last;
  logic [WIDTH-1:0]           cnt;
  logic [NREQ-1:0][WIDTH-1:0] load_arr;
  arb_t                       arb;
  logic                       abort;

  assign load_arr = load_val_i;

`ifdef CNT_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // Round-robin pick: first requesting index after 'last', wrapping. The
  // first hit in scan order wins, so the just-served requester is checked
  // last and can't starve anyone.
  always_comb begin
    arb = '0;
    for (int i = 0; i < NREQ; i++) begin
      int            pos;
      logic [IW-1:0] idx;
      pos = (int'(last) + 1 + i) % NREQ;
      idx = IW'(pos);
      if (!arb.vld && req_i[idx]) begin
        arb.vld = 1'b1;
        arb.idx = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= '0;
      last   <= IW'(NREQ - 1);
      cnt    <= '0;
      gnt_o  <= '0;
      done_o <= '0;
`ifdef CNT_ABORT_EN
      aborted_o <= 1'b0;
`endif
    end else begin
      // Pulses default low; only the transition that owns them sets them.
      done_o <= '0;
`ifdef CNT_ABORT_EN
      aborted_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (arb.vld) begin
            sel   <= arb.idx;
            gnt_o <= ONE << arb.idx;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            gnt_o <= '0;
            last  <= sel;
            state <= IDLE;
`ifdef CNT_ABORT_EN
            aborted_o <= 1'b1;
`endif
          end else begin
            // Preload is sampled only here; later changes don't matter.
            cnt   <= load_arr[sel];
            state <= COUNT;
          end
        end
        COUNT: begin
          if (abort) begin
            gnt_o <= '0;
            last  <= sel;
            state <= IDLE;
`ifdef CNT_ABORT_EN
            aborted_o <= 1'b1;
`endif
          end else if (cnt == CNT_MAX) begin
            // Exit at all-ones regardless of cnt_en_i; counter never wraps.
            done_o <= ONE << sel;
            state  <= DONE;
          end else if (cnt_en_i) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          gnt_o <= '0;
          last  <= sel;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);
  assign cnt_o  = cnt;
  assign tc_o   = (state == COUNT) && (cnt == CNT_MAX);

endmodule

// File: tb/tb_cnt_load_sched.sv
// Self-checking bench for cnt_load_sched. Cycle k of a scenario is the clock
// period in which its stimulus for step k is driven (just after a rising
// edge); outputs are sampled on the following falling edge. Expected done
// pulses (requester, absolute cycle) go into a scoreboard queue and are
// compared by a monitor whenever done_o is nonzero.
module tb_cnt_load_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_i;
  logic [NREQ*WIDTH-1:0] load_val_i;
  logic                  cnt_en_i;
  logic [NREQ-1:0]       gnt_o;
  logic [NREQ-1:0]       done_o;
  logic                  busy_o;
  logic [WIDTH-1:0]      cnt_o;
  logic                  tc_o;
`ifdef CNT_ABORT_EN
  logic                  abort_i;
  logic                  aborted_o;
`endif

  cnt_load_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .load_val_i (load_val_i),
    .cnt_en_i   (cnt_en_i),
`ifdef CNT_ABORT_EN
    .abort_i    (abort_i),
    .aborted_o  (aborted_o),
`endif
    .gnt_o      (gnt_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .cnt_o      (cnt_o),
    .tc_o       (tc_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  // Scoreboard monitor for done pulses.
  exp_t            mon_e;
  logic [NREQ-1:0] mon_oh;
  always @(negedge clk) begin
    if (done_o !== '0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected: done_o=%b at cycle %0d, expected no pulse", done_o, cyc);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_oh = 4'(1) << mon_e.idx;
        if (done_o !== mon_oh || cyc != mon_e.cyc) begin
          fails++;
          $display("FAIL done_pulse: got done_o=%b at cycle %0d, expected %b at cycle %0d",
                   done_o, cyc, mon_oh, mon_e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_l(input int k, input logic [WIDTH-1:0] v);
    load_val_i[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_i = '0;
    step();
    rst = 1'b0;
  endtask

  // Bounded wait for outstanding expected done pulses.
  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) step();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: %0d done pulses still outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_i = '0;
    load_val_i = '0;
    cnt_en_i = 1'b1;
`ifdef CNT_ABORT_EN
    abort_i = 1'b0;
`endif
    step();
    step();
    @(negedge clk);
    tests++; if (gnt_o !== '0) begin fails++; $display("FAIL reset_gnt: got %b, expected 0", gnt_o); end
    tests++; if (done_o !== '0) begin fails++; $display("FAIL reset_done: got %b, expected 0", done_o); end
    tests++; if (cnt_o !== '0) begin fails++; $display("FAIL reset_cnt: got %h, expected 0", cnt_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy_o); end
    tests++; if (tc_o !== 1'b0) begin fails++; $display("FAIL reset_tc: got %b, expected 0", tc_o); end
`ifdef CNT_ABORT_EN
    tests++; if (aborted_o !== 1'b0) begin fails++; $display("FAIL reset_aborted: got %b, expected 0", aborted_o); end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int c0;
    c0 = cyc;
    req_i = 4'b0001;
    set_l(0, 8'hFC);
    cnt_en_i = 1'b1;
    exp_q.push_back('{idx: 0, cyc: c0 + 6});
    for (int k = 0; k <= 7; k++) begin
      if (k == 6) req_i = '0;
      @(negedge clk);
      if (k == 0) begin
        tests++; if (gnt_o !== 4'b0000) begin fails++; $display("FAIL single_gnt_c0: got %b, expected 0000", gnt_o); end
      end
      if (k == 1) begin
        tests++; if (gnt_o !== 4'b0001) begin fails++; $display("FAIL single_gnt_c1: got %b, expected 0001", gnt_o); end
      end
      if (k >= 2 && k <= 5) begin
        tests++;
        if (cnt_o !== 8'(8'hFC + k - 2)) begin
          fails++; $display("FAIL single_cnt_c%0d: got %h, expected %h", k, cnt_o, 8'(8'hFC + k - 2));
        end
        tests++;
        if (tc_o !== (k == 5)) begin
          fails++; $display("FAIL single_tc_c%0d: got %b, expected %b", k, tc_o, (k == 5));
        end
      end
      if (k == 6) begin
        tests++; if (done_o !== 4'b0001) begin fails++; $display("FAIL single_done_c6: got %b, expected 0001", done_o); end
      end
      if (k == 7) begin
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL single_busy_c7: got %b, expected 0", busy_o); end
        tests++; if (gnt_o !== 4'b0000) begin fails++; $display("FAIL single_gnt_c7: got %b, expected 0000", gnt_o); end
      end
      step();
    end
    drain("single");
  endtask

  task automatic test_rr();
    int c0;
    logic [NREQ-1:0] eg;
    do_reset();
    c0 = cyc;
    for (int r = 0; r < NREQ; r++) set_l(r, 8'hFF);
    req_i = 4'b1111;
    cnt_en_i = 1'b1;
    for (int n = 0; n < 5; n++) exp_q.push_back('{idx: n % NREQ, cyc: c0 + 3 + 4 * n});
    for (int k = 0; k <= 20; k++) begin
      if (k == 19) req_i = '0;
      @(negedge clk);
      if (k % 4 == 1) begin
        eg = 4'(1) << ((k / 4) % NREQ);
        tests++;
        if (gnt_o !== eg) begin fails++; $display("FAIL rr_gnt_c%0d: got %b, expected %b", k, gnt_o, eg); end
      end
      step();
    end
    drain("rr");
  endtask

  task automatic test_stall();
    int c0;
    c0 = cyc;
    req_i = 4'b0100;
    set_l(2, 8'hFD);
    exp_q.push_back('{idx: 2, cyc: c0 + 8});
    for (int k = 0; k <= 9; k++) begin
      cnt_en_i = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
      if (k == 8) req_i = '0;
      @(negedge clk);
      if (k == 1) begin
        tests++; if (gnt_o !== 4'b0100) begin fails++; $display("FAIL stall_gnt: got %b, expected 0100", gnt_o); end
      end
      if (k == 2) begin
        tests++; if (cnt_o !== 8'hFD) begin fails++; $display("FAIL stall_cnt_c2: got %h, expected fd", cnt_o); end
      end
      if (k >= 3 && k <= 6) begin
        tests++; if (cnt_o !== 8'hFE) begin fails++; $display("FAIL stall_cnt_c%0d: got %h, expected fe", k, cnt_o); end
      end
      if (k == 7) begin
        tests++; if (tc_o !== 1'b1) begin fails++; $display("FAIL stall_tc_c7: got %b, expected 1", tc_o); end
      end
      step();
    end
    cnt_en_i = 1'b1;
    drain("stall");
  endtask

  task automatic test_preload();
    int c0;
    c0 = cyc;
    req_i = 4'b1000;
    set_l(3, 8'hF8);
    exp_q.push_back('{idx: 3, cyc: c0 + 10});
    for (int k = 0; k <= 11; k++) begin
      if (k == 2) begin
        req_i = '0;
        set_l(3, 8'h00);
      end
      @(negedge clk);
      if (k == 2) begin
        tests++; if (cnt_o !== 8'hF8) begin fails++; $display("FAIL preload_cnt_c2: got %h, expected f8", cnt_o); end
      end
      if (k == 5) begin
        tests++; if (gnt_o !== 4'b1000) begin fails++; $display("FAIL preload_gnt_c5: got %b, expected 1000", gnt_o); end
      end
      if (k == 6) begin
        tests++; if (cnt_o !== 8'hFC) begin fails++; $display("FAIL preload_cnt_c6: got %h, expected fc", cnt_o); end
      end
      if (k == 10) begin
        tests++; if (done_o !== 4'b1000) begin fails++; $display("FAIL preload_done_c10: got %b, expected 1000", done_o); end
      end
      step();
    end
    drain("preload");
  endtask

  task automatic test_reset_mid();
    int c0;
    c0 = cyc;
    req_i = 4'b0010;
    set_l(1, 8'h7E);
    set_l(0, 8'hFF);
    for (int k = 0; k <= 9; k++) begin
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        rst = 1'b0;
        req_i = 4'b0011;
        exp_q.push_back('{idx: 0, cyc: c0 + 8});
      end
      if (k == 7) req_i = '0;
      @(negedge clk);
      if (k == 1) begin
        tests++; if (gnt_o !== 4'b0010) begin fails++; $display("FAIL rstmid_gnt_c1: got %b, expected 0010", gnt_o); end
      end
      if (k == 4) begin
        tests++; if (cnt_o !== 8'h80) begin fails++; $display("FAIL rstmid_cnt_c4: got %h, expected 80", cnt_o); end
      end
      if (k == 5) begin
        tests++;
        if ({gnt_o, done_o, busy_o, tc_o} !== '0 || cnt_o !== '0) begin
          fails++;
          $display("FAIL rstmid_outputs_c5: got gnt=%b done=%b busy=%b tc=%b cnt=%h, expected all 0",
                   gnt_o, done_o, busy_o, tc_o, cnt_o);
        end
      end
      if (k == 6) begin
        tests++; if (gnt_o !== 4'b0001) begin fails++; $display("FAIL rstmid_gnt_c6: got %b, expected 0001", gnt_o); end
      end
      step();
    end
    drain("rstmid");
  endtask

`ifdef CNT_ABORT_EN
  task automatic test_abort();
    int c0;
    c0 = cyc;
    req_i = 4'b0110;
    set_l(1, 8'h0E);
    set_l(2, 8'hFF);
    abort_i = 1'b0;
    exp_q.push_back('{idx: 2, cyc: c0 + 8});
    for (int k = 0; k <= 10; k++) begin
      if (k == 4) abort_i = 1'b1;
      if (k == 5) begin
        abort_i = 1'b0;
        req_i = 4'b0100;
      end
      if (k == 8) req_i = '0;
      @(negedge clk);
      if (k == 1) begin
        tests++; if (gnt_o !== 4'b0010) begin fails++; $display("FAIL abort_gnt_c1: got %b, expected 0010", gnt_o); end
      end
      if (k == 4) begin
        tests++; if (cnt_o !== 8'h10) begin fails++; $display("FAIL abort_cnt_c4: got %h, expected 10", cnt_o); end
      end
      if (k == 5) begin
        tests++; if (aborted_o !== 1'b1) begin fails++; $display("FAIL abort_pulse_c5: got %b, expected 1", aborted_o); end
        tests++;
        if (gnt_o !== '0 || done_o !== '0 || busy_o !== 1'b0) begin
          fails++;
          $display("FAIL abort_state_c5: got gnt=%b done=%b busy=%b, expected 0", gnt_o, done_o, busy_o);
        end
      end
      if (k == 6) begin
        tests++; if (aborted_o !== 1'b0) begin fails++; $display("FAIL abort_pulse_c6: got %b, expected 0", aborted_o); end
        tests++; if (gnt_o !== 4'b0100) begin fails++; $display("FAIL abort_gnt_c6: got %b, expected 0100", gnt_o); end
      end
      step();
    end
    drain("abort");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_stall();
    test_preload();
    test_reset_mid();
`ifdef CNT_ABORT_EN
    test_abort();
`endif
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
